// File: rtl/mx3_rr_sel.sv
// Round-robin select sequencer for a 3:1 mx3 mux cell: arbitrates three requesters,
// drives registered cmd0/cmd1 selects and a valid/ready handshake toward the consumer.
module mx3_rr_sel #(
   parameter int unsigned LOCK_MAX = 4   // beats per ownership before forced rotation, 1..15
) (
   input  logic       ck,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic       out_ready,
   output logic [2:0] gnt,
   output logic       cmd0,
   output logic       cmd1,
   output logic       out_valid,
   output logic       busy
);

   localparam int unsigned NSRC = 3;
   localparam int unsigned PW   = 2;
   localparam int unsigned CW   = 4;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [NSRC-1:0] gnt_nxt;
   logic            cmd0_nxt;
   logic            cmd1_nxt;
   logic            busy_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;

   logic            xfer;
   logic            rel_drop;
   logic            rel_cap;
   logic            release_c;
   logic [NSRC-1:0] pick_all;
   logic [NSRC-1:0] pick_other;

   // First set request bit searching from p upward, modulo 3; result is one-hot or zero.
   function automatic logic [NSRC-1:0] rr_pick(input logic [NSRC-1:0] r, input logic [PW-1:0] p);
      logic [NSRC-1:0] w;
      w = 3'b000;
      case (p)
         2'd1:    w = r[1] ? 3'b010 : r[2] ? 3'b100 : r[0] ? 3'b001 : 3'b000;
         2'd2:    w = r[2] ? 3'b100 : r[0] ? 3'b001 : r[1] ? 3'b010 : 3'b000;
         default: w = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
      endcase
      return w;
   endfunction

   // Pointer follows the winner: next search starts one past it.
   function automatic logic [PW-1:0] ptr_after(input logic [NSRC-1:0] w);
      logic [PW-1:0] p;
      p = 2'd0;
      if (w[0])      p = 2'd1;
      else if (w[1]) p = 2'd2;
      return p;
   endfunction

   // State register: all registered outputs and bookkeeping.
   always_ff @(posedge ck) begin
      if (rst) begin
         state <= S_IDLE;
         gnt   <= '0;
         cmd0  <= 1'b0;
         cmd1  <= 1'b0;
         busy  <= 1'b0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         cmd0  <= cmd0_nxt;
         cmd1  <= cmd1_nxt;
         busy  <= busy_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Handshake and release conditions derived from the current grant.
   always_comb begin
      out_valid  = |(gnt & req);
      xfer       = out_valid & out_ready;
      rel_drop   = ~out_valid;
      rel_cap    = xfer && (cnt == CW'(LOCK_MAX - 1));
      release_c  = rel_drop | rel_cap;
      pick_all   = rr_pick(req, ptr);
      pick_other = rr_pick(req & ~gnt, ptr);
   end

   // Next-state: choose a winner (if any) and load grant, selects, pointer and count.
   always_comb begin
      logic            do_grant;
      logic [NSRC-1:0] win;
      state_nxt = state;
      gnt_nxt   = gnt;
      cmd0_nxt  = cmd0;
      cmd1_nxt  = cmd1;
      busy_nxt  = busy;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      do_grant  = 1'b0;
      win       = '0;

      case (state)
         S_IDLE: begin
            if (|req) begin
               do_grant = 1'b1;
               win      = pick_all;
            end
         end
         S_GRANT: begin
            if (release_c) begin
               if (|pick_other) begin
                  do_grant = 1'b1;
                  win      = pick_other;
               end else if (rel_cap && |(gnt & req)) begin
                  do_grant = 1'b1;
                  win      = gnt;
               end else begin
                  // Idle: selects stay on the last owner so the mux output does not move.
                  gnt_nxt   = '0;
                  busy_nxt  = 1'b0;
                  state_nxt = S_IDLE;
               end
            end else if (xfer) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase

      if (do_grant) begin
         gnt_nxt   = win;
         cmd0_nxt  = win[1] | win[2];
         cmd1_nxt  = win[1];
         ptr_nxt   = ptr_after(win);
         cnt_nxt   = '0;
         busy_nxt  = 1'b1;
         state_nxt = S_GRANT;
      end
   end

   a_gnt_onehot0: assert property (@(posedge ck) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_mx3_rr_sel.sv
// Directed bench for mx3_rr_sel: hand-computed grant/select sequences, sampled 1ns after ck rise.
module tb_mx3_rr_sel;

   logic       ck;
   logic       rst;
   logic [2:0] req;
   logic       out_ready;
   logic [2:0] gnt;
   logic       cmd0;
   logic       cmd1;
   logic       out_valid;
   logic       busy;

   int n_chk;
   int n_err;

   mx3_rr_sel #(.LOCK_MAX(4)) dut (
      .ck        (ck),
      .rst       (rst),
      .req       (req),
      .out_ready (out_ready),
      .gnt       (gnt),
      .cmd0      (cmd0),
      .cmd1      (cmd1),
      .out_valid (out_valid),
      .busy      (busy)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge ck);
      #1;
   endtask

   // Full observable state: gnt, {cmd1,cmd0}, busy, out_valid.
   task automatic chk_all(input string tag, input logic [2:0] g, input logic [1:0] c,
                          input logic b, input logic v);
      chk({tag, ".gnt"}, 8'(gnt), 8'(g));
      chk({tag, ".cmd"}, 8'({cmd1, cmd0}), 8'(c));
      chk({tag, ".busy"}, 8'(busy), 8'(b));
      chk({tag, ".vld"}, 8'(out_valid), 8'(v));
   endtask

   initial begin
      logic [2:0] seq [4];
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      req = 3'b000;
      out_ready = 1'b0;
      cyc();
      cyc();
      chk_all("rst", 3'b000, 2'b00, 1'b0, 1'b0);

      // Single requester 0: one-cycle latency, cap re-grant, then cnt proven reset.
      rst = 1'b0;
      req = 3'b001;
      out_ready = 1'b1;
      cyc();
      chk_all("g0_first", 3'b001, 2'b00, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("g0_hold", 8'(gnt), 8'(3'b001));
      end
      req = 3'b011;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("g0_regrant_cnt", 8'(gnt), 8'(3'b001));
      end
      cyc();
      chk_all("g0_to_g1", 3'b010, 2'b11, 1'b1, 1'b1);

      // All three requesting: strict rotation, no idle bubble.
      seq[0] = 3'b010;
      seq[1] = 3'b100;
      seq[2] = 3'b001;
      seq[3] = 3'b010;
      req = 3'b111;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk("rot_gnt", 8'(gnt), 8'(seq[k / 4]));
         chk("rot_busy", 8'(busy), 8'h01);
      end
      chk("rot_cmd", 8'({cmd1, cmd0}), 8'(2'b11));

      // Stall: no beats counted while out_ready=0.
      req = 3'b011;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_all("stall", 3'b010, 2'b11, 1'b1, 1'b1);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_beats", 8'(gnt), 8'(3'b010));
      end
      cyc();
      chk_all("stall_rel", 3'b001, 2'b00, 1'b1, 1'b1);

      // Owner drop with another request: direct handoff.
      req = 3'b100;
      cyc();
      chk_all("drop0_to2", 3'b100, 2'b01, 1'b1, 1'b1);
      out_ready = 1'b0;
      req = 3'b001;
      cyc();
      chk_all("drop2_to0", 3'b001, 2'b00, 1'b1, 1'b1);

      // Release to idle, then ptr=1 must pick source 2 over source 0.
      req = 3'b000;
      cyc();
      chk_all("idle0", 3'b000, 2'b00, 1'b0, 1'b0);
      req = 3'b101;
      cyc();
      chk_all("ptr1_pick", 3'b100, 2'b01, 1'b1, 1'b1);
      req = 3'b000;
      cyc();
      chk_all("idle2_hold", 3'b000, 2'b01, 1'b0, 1'b0);
      cyc();
      chk_all("idle2_hold2", 3'b000, 2'b01, 1'b0, 1'b0);

      // Mid-burst reset on owner 1 with cnt=2.
      req = 3'b010;
      out_ready = 1'b1;
      cyc();
      chk_all("g1_burst", 3'b010, 2'b11, 1'b1, 1'b1);
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      chk_all("mid_rst", 3'b000, 2'b00, 1'b0, 1'b0);
      rst = 1'b0;
      req = 3'b100;
      cyc();
      chk_all("post_rst", 3'b100, 2'b01, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
